// File: rtl/alu_z_capture.sv
// Result capture stage behind the ALU: waits out the op latency, latches ResultHi/Lo
// into Z_Hi/Z_Lo, then streams one (normal) or two (MUL/DIV, lo then hi) 32-bit beats.
module alu_z_capture #(
    parameter int          MUL_LAT = 2,
    parameter int          DIV_LAT = 1,
    parameter logic [4:0]  OP_MUL  = 5'b10000,
    parameter logic [4:0]  OP_DIV  = 5'b01111
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    output logic        busy,
    output logic        drop,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_is_hi
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND_LO,
        ST_SEND_HI
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wide_q, wide_d;
    logic        capture;
    logic        handshake;

    // Counter preload is L-1 so capture lands exactly L edges after the start edge.
    function automatic logic [3:0] wait_preload(input logic [4:0] code);
        if (code == OP_MUL)
            return 4'(MUL_LAT - 1);
        else if (code == OP_DIV)
            return 4'(DIV_LAT - 1);
        else
            return 4'd0;
    endfunction

    assign handshake = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wide_d  = wide_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_preload(op);
                    wide_d  = (op == OP_MUL) || (op == OP_DIV);
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    capture = 1'b1;
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (handshake)
                    state_d = wide_q ? ST_SEND_HI : ST_IDLE;
            end
            ST_SEND_HI: begin
                if (handshake)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wide_q  <= 1'b0;
            drop    <= 1'b0;
            z_hi    <= 32'd0;
            z_lo    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wide_q  <= wide_d;
            drop    <= start && (state_q != ST_IDLE);
            if (capture) begin
                z_hi <= alu_hi;
                z_lo <= alu_lo;
            end
        end
    end

    // Channel outputs decode from state only, so out_ready never reaches out_valid.
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
    assign out_is_hi = (state_q == ST_SEND_HI);
    assign out_data  = (state_q == ST_SEND_LO) ? z_lo :
                       (state_q == ST_SEND_HI) ? z_hi : 32'd0;

endmodule

// File: tb/tb_alu_z_capture.sv
// Bench for alu_z_capture: transaction-level model with a per-cycle compare process,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_z_capture;

    localparam int         MUL_LAT = 2;
    localparam int         DIV_LAT = 1;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_NEG  = 5'b00011;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] alu_hi = 32'd0;
    logic [31:0] alu_lo = 32'd0;
    logic        out_ready = 1'b0;
    logic        busy, drop, out_valid, out_is_hi;
    logic [31:0] z_hi, z_lo, out_data;

    int checks = 0;
    int errors = 0;

    alu_z_capture #(
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)
    ) dut (
        .clock(clock), .clear(clear), .start(start), .op(op),
        .alu_hi(alu_hi), .alu_lo(alu_lo), .busy(busy), .drop(drop),
        .z_hi(z_hi), .z_lo(z_lo), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_is_hi(out_is_hi)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is either counting down to capture or draining a
    // queue of beats; bit 32 of a queued beat marks the high word.
    logic        m_busy = 1'b0;
    int          m_rem = 0;
    logic [32:0] m_q[$];
    logic [31:0] m_zhi = 32'd0;
    logic [31:0] m_zlo = 32'd0;
    logic        m_drop = 1'b0;
    logic        m_wide = 1'b0;

    function automatic int lat_of(input logic [4:0] code);
        if (code == OP_MUL) return MUL_LAT;
        if (code == OP_DIV) return DIV_LAT;
        return 1;
    endfunction

    always @(posedge clock) begin
        if (!clear) begin
            m_busy = 1'b0; m_rem = 0; m_q.delete();
            m_zhi = 32'd0; m_zlo = 32'd0; m_drop = 1'b0; m_wide = 1'b0;
        end else begin
            m_drop = start && m_busy;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_rem  = lat_of(op);
                    m_wide = (op == OP_MUL) || (op == OP_DIV);
                end
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_zhi = alu_hi;
                    m_zlo = alu_lo;
                    m_q.push_back({1'b0, alu_lo});
                    if (m_wide) m_q.push_back({1'b1, alu_hi});
                end
            end else if (out_ready && m_q.size() > 0) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 1'b0;
            end
        end
        #1;
        chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
        chk("m_drop", {31'd0, drop}, {31'd0, m_drop});
        chk("m_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
        chk("m_data", out_data, (m_q.size() > 0) ? m_q[0][31:0] : 32'd0);
        chk("m_is_hi", {31'd0, out_is_hi}, {31'd0, (m_q.size() > 0) ? m_q[0][32] : 1'b0});
        chk("m_z_hi", z_hi, m_zhi);
        chk("m_z_lo", z_lo, m_zlo);
    end

    task automatic drive(input logic st, input logic [4:0] o, input logic [31:0] hi,
                         input logic [31:0] lo, input logic rdy);
        start = st; op = o; alu_hi = hi; alu_lo = lo; out_ready = rdy;
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    initial begin
        repeat (2) nxt();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_z_lo", z_lo, 32'd0);
        clear = 1'b1;
        nxt();

        // ADD, single beat
        drive(1'b1, OP_ADD, 32'd0, 32'h7, 1'b1);
        nxt(); start = 1'b0;
        chk("add_busy", {31'd0, busy}, 32'd1);
        chk("add_nvalid", {31'd0, out_valid}, 32'd0);
        nxt();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_data", out_data, 32'h7);
        chk("add_is_hi", {31'd0, out_is_hi}, 32'd0);
        nxt();
        chk("add_idle", {31'd0, busy}, 32'd0);
        chk("add_z_lo", z_lo, 32'h7);

        // MUL with 3 stalled cycles
        drive(1'b1, OP_MUL, 32'h1, 32'hFFFF_FFFE, 1'b0);
        nxt(); start = 1'b0;
        chk("mul_e0_valid", {31'd0, out_valid}, 32'd0);
        nxt();
        chk("mul_e1_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            alu_hi = 32'hDEAD_BEEF; alu_lo = 32'hCAFE_F00D;
            chk("mul_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("mul_stall_data", out_data, 32'hFFFF_FFFE);
            chk("mul_stall_is_hi", {31'd0, out_is_hi}, 32'd0);
        end
        out_ready = 1'b1;
        nxt();
        chk("mul_hi_data", out_data, 32'h1);
        chk("mul_hi_flag", {31'd0, out_is_hi}, 32'd1);
        nxt();
        chk("mul_idle", {31'd0, busy}, 32'd0);
        chk("mul_z_hi", z_hi, 32'h1);
        chk("mul_z_lo", z_lo, 32'hFFFF_FFFE);

        // DIV: quotient then remainder
        drive(1'b1, OP_DIV, 32'd3, 32'd5, 1'b1);
        nxt(); start = 1'b0;
        nxt();
        chk("div_lo", out_data, 32'd5);
        nxt();
        chk("div_hi", out_data, 32'd3);
        chk("div_hi_flag", {31'd0, out_is_hi}, 32'd1);
        nxt();
        chk("div_idle", {31'd0, busy}, 32'd0);
        chk("div_z_hi", z_hi, 32'd3);
        chk("div_z_lo", z_lo, 32'd5);

        // start while busy: in WAIT and on the final handshake
        drive(1'b1, OP_ADD, 32'd0, 32'h11, 1'b0);
        nxt();
        nxt(); start = 1'b0;
        chk("drop_wait", {31'd0, drop}, 32'd1);
        chk("drop_wait_data", out_data, 32'h11);
        nxt();
        chk("drop_clr", {31'd0, drop}, 32'd0);
        start = 1'b1; alu_lo = 32'h99; out_ready = 1'b1;
        nxt(); start = 1'b0;
        chk("drop_last", {31'd0, drop}, 32'd1);
        chk("drop_last_idle", {31'd0, busy}, 32'd0);
        nxt();
        chk("drop_no_start", {31'd0, busy}, 32'd0);
        chk("drop_z_lo", z_lo, 32'h11);

        // async clear mid-WAIT of MUL
        drive(1'b1, OP_MUL, 32'hAAAA, 32'hBBBB, 1'b1);
        nxt(); start = 1'b0;
        #2 clear = 1'b0;
        #1;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_z_lo", z_lo, 32'd0);
        chk("clr_data", out_data, 32'd0);
        nxt();
        clear = 1'b1;
        drive(1'b1, OP_ADD, 32'd0, 32'h22, 1'b1);
        nxt(); start = 1'b0;
        nxt();
        chk("clr_add_data", out_data, 32'h22);
        nxt();
        chk("clr_add_idle", {31'd0, busy}, 32'd0);

        // back-to-back ADD then NEG
        drive(1'b1, OP_ADD, 32'd0, 32'h33, 1'b1);
        nxt(); start = 1'b0;
        nxt();
        chk("b2b_add", out_data, 32'h33);
        nxt();
        drive(1'b1, OP_NEG, 32'd0, 32'hFFFF_FFCD, 1'b1);
        nxt(); start = 1'b0;
        nxt();
        chk("b2b_neg", out_data, 32'hFFFF_FFCD);
        nxt();
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] o;
            case ($urandom_range(0, 3))
                0: o = OP_MUL;
                1: o = OP_DIV;
                default: o = 5'($urandom);
            endcase
            drive(($urandom_range(0, 3) == 0), o, $urandom, $urandom,
                  ($urandom_range(0, 2) != 0));
            clear = ($urandom_range(0, 199) != 0);
            nxt();
        end
        clear = 1'b1; start = 1'b0;
        repeat (3) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
